// File: rtl/imm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ctrl_pkg
//  Description : Shared types and constants for the immediate-class control
//                sequencer: state encodings, opcodes, ALU select codes,
//                opcode classes and the strobe bundle layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_ctrl_pkg;

    // Present_state encoding is visible on the debug port, so values are fixed.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_T0      = 4'd1,
        S_T1      = 4'd2,
        S_T2      = 4'd3,
        S_T3      = 4'd4,
        S_T4      = 4'd5,
        S_T5      = 4'd6,
        S_HALTED  = 4'd7,
        S_ILLEGAL = 4'd8
    } state_t;

    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    // C_LDI must stay at zero: it doubles as the cleared opcode latch value.
    typedef enum logic [1:0] {
        C_LDI       = 2'd0,
        C_ARITH_ADD = 2'd1,
        C_AND       = 2'd2,
        C_OR        = 2'd3
    } op_class_t;

    // Field order is the bit order of the flattened strobe vector (MSB first).
    typedef struct packed {
        logic PCout;
        logic MARin;
        logic IncPC;
        logic PCin;
        logic Read;
        logic MDRin;
        logic MDRout;
        logic IRin;
        logic Yin;
        logic GRA;
        logic GRB;
        logic Rin;
        logic Rout;
        logic BAout;
        logic Cout;
        logic Zin;
        logic Zlowout;
        logic Instr_done;
        logic Halted;
        logic Illegal;
    } strobes_t;

    localparam int STB_W = $bits(strobes_t);

    typedef struct packed {
        logic      valid;
        op_class_t cls;
    } op_decode_t;

    // Maps an opcode to its execution class; valid=0 for HALT and all
    // unsupported opcodes (the FSM separates those two cases itself).
    function automatic op_decode_t decode_opcode(input logic [4:0] op);
        op_decode_t d;
        d.valid = 1'b1;
        d.cls   = C_LDI;
        case (op)
            OP_LDI:  d.cls = C_LDI;
            OP_ADDI: d.cls = C_ARITH_ADD;
            OP_ANDI: d.cls = C_AND;
            OP_ORI:  d.cls = C_OR;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage : imm_ctrl_pkg
`default_nettype wire

// File: rtl/imm_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ctrl_decode
//  Description : Combinational Moore decode of sequencer state plus opcode
//                class into the full datapath strobe vector and ALU select.
//  Ports       : state      in  4   current FSM state
//                cls        in  2   opcode class (live in T3, latched in T4)
//                cls_valid  in  1   class is a supported immediate op
//                strobes    out 20  flattened strobe bundle (see strobes_t)
//                operation  out 5   ALU select, non-zero only in T4
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ctrl_decode
    import imm_ctrl_pkg::*;
(
    input  logic [3:0]       state,
    input  logic [1:0]       cls,
    input  logic             cls_valid,
    output logic [STB_W-1:0] strobes,
    output logic [4:0]       operation
);

    strobes_t w_stb;

    always_comb begin
        w_stb     = '0;
        operation = ALU_NOP;
        case (state_t'(state))
            S_T0: begin
                w_stb.PCout = 1'b1;
                w_stb.MARin = 1'b1;
                w_stb.IncPC = 1'b1;
                w_stb.PCin  = 1'b1;
            end
            S_T1: begin
                w_stb.Read  = 1'b1;
                w_stb.MDRin = 1'b1;
            end
            S_T2: begin
                w_stb.MDRout = 1'b1;
                w_stb.IRin   = 1'b1;
            end
            S_T3: begin
                // HALT and unsupported opcodes leave T3 silent.
                if (cls_valid) begin
                    w_stb.GRB = 1'b1;
                    w_stb.Yin = 1'b1;
                    if (op_class_t'(cls) == C_LDI) w_stb.BAout = 1'b1;
                    else                           w_stb.Rout  = 1'b1;
                end
            end
            S_T4: begin
                w_stb.Cout = 1'b1;
                w_stb.Zin  = 1'b1;
                case (op_class_t'(cls))
                    C_AND:   operation = ALU_AND;
                    C_OR:    operation = ALU_OR;
                    default: operation = ALU_ADD;
                endcase
            end
            S_T5: begin
                w_stb.Zlowout    = 1'b1;
                w_stb.GRA        = 1'b1;
                w_stb.Rin        = 1'b1;
                w_stb.Instr_done = 1'b1;
            end
            S_HALTED:  w_stb.Halted  = 1'b1;
            S_ILLEGAL: w_stb.Illegal = 1'b1;
            default: ;
        endcase
    end

    assign strobes = w_stb;

endmodule : imm_ctrl_decode
`default_nettype wire

// File: rtl/imm_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : imm_ctrl_seq
//  Description : Control sequencer for instruction fetch and the immediate
//                class (ldi/addi/andi/ori/halt). Holds the FSM, the memory
//                wait-state counter, the opcode-class latch and the retired
//                instruction counter; strobes come from imm_ctrl_decode.
//  Ports       : Clock, Reset_n (async active-low), Run, ir_data[DATA_W]
//                fetch strobes  PCout MARin IncPC PCin Read MDRin MDRout IRin
//                exec strobes   Yin GRA GRB Rin Rout BAout Cout Zin Zlowout
//                operation[5], Present_state[4], Instr_done, Halted, Illegal,
//                instr_count[CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_ctrl_seq
    import imm_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OPW      = 5,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Run,
    input  logic [DATA_W-1:0] ir_data,
    output logic              PCout,
    output logic              MARin,
    output logic              IncPC,
    output logic              PCin,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic              IRin,
    output logic              Yin,
    output logic              GRA,
    output logic              GRB,
    output logic              Rin,
    output logic              Rout,
    output logic              BAout,
    output logic              Cout,
    output logic              Zin,
    output logic              Zlowout,
    output logic [4:0]        operation,
    output logic [3:0]        Present_state,
    output logic              Instr_done,
    output logic              Halted,
    output logic              Illegal,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [3:0] c_WAIT_INIT = 4'(MEM_WAIT);

    state_t           r_state;
    logic [3:0]       r_wait;
    logic [CNT_W-1:0] r_count;
    op_class_t        r_cls;

    logic [OPW-1:0]   w_opcode;
    op_decode_t       w_dec;
    logic             w_is_halt;
    logic [1:0]       w_cls_sel;
    logic             w_cls_valid;
    strobes_t         w_stb;
    logic [STB_W-1:0] w_stb_vec;
    logic             w_unused_ir;

    assign w_opcode    = ir_data[DATA_W-1 -: OPW];
    assign w_dec       = decode_opcode(5'(w_opcode));
    assign w_is_halt   = (5'(w_opcode) == OP_HALT);
    assign w_unused_ir = ^ir_data[DATA_W-OPW-1:0];

    // T3 strobes follow the opcode currently on the IR; T4 uses the latch.
    assign w_cls_sel   = (r_state == S_T3) ? w_dec.cls   : r_cls;
    assign w_cls_valid = (r_state == S_T3) ? w_dec.valid : 1'b1;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_count <= '0;
            r_cls   <= C_LDI;
        end else begin
            case (r_state)
                S_IDLE: if (Run) r_state <= S_T0;
                S_T0: begin
                    r_state <= S_T1;
                    r_wait  <= c_WAIT_INIT;
                end
                // Counter hits zero on the last read cycle: MEM_WAIT+1 cycles.
                S_T1: begin
                    if (r_wait == 4'd0) r_state <= S_T2;
                    else                r_wait  <= r_wait - 4'd1;
                end
                S_T2: r_state <= S_T3;
                S_T3: begin
                    if (w_dec.valid) begin
                        r_cls   <= w_dec.cls;
                        r_state <= S_T4;
                    end else if (w_is_halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_state <= S_ILLEGAL;
                    end
                end
                S_T4: r_state <= S_T5;
                S_T5: begin
                    r_count <= r_count + 1'b1;
                    r_state <= Run ? S_T0 : S_IDLE;
                end
                S_HALTED:  r_state <= S_HALTED;
                S_ILLEGAL: r_state <= S_ILLEGAL;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    imm_ctrl_decode u_decode (
        .state     (r_state),
        .cls       (w_cls_sel),
        .cls_valid (w_cls_valid),
        .strobes   (w_stb_vec),
        .operation (operation)
    );

    assign w_stb = w_stb_vec;

    assign PCout         = w_stb.PCout;
    assign MARin         = w_stb.MARin;
    assign IncPC         = w_stb.IncPC;
    assign PCin          = w_stb.PCin;
    assign Read          = w_stb.Read;
    assign MDRin         = w_stb.MDRin;
    assign MDRout        = w_stb.MDRout;
    assign IRin          = w_stb.IRin;
    assign Yin           = w_stb.Yin;
    assign GRA           = w_stb.GRA;
    assign GRB           = w_stb.GRB;
    assign Rin           = w_stb.Rin;
    assign Rout          = w_stb.Rout;
    assign BAout         = w_stb.BAout;
    assign Cout          = w_stb.Cout;
    assign Zin           = w_stb.Zin;
    assign Zlowout       = w_stb.Zlowout;
    assign Instr_done    = w_stb.Instr_done;
    assign Halted        = w_stb.Halted;
    assign Illegal       = w_stb.Illegal;
    assign Present_state = r_state;
    assign instr_count   = r_count;

endmodule : imm_ctrl_seq
`default_nettype wire
